// File: rtl/ofdm_pkg.sv
// Shared OFDM receive-path definitions: FFT size defaults, scaling widths and the
// write/read state encodings used by the FFT frame sink.
package ofdm_pkg;

  localparam int unsigned NFFT_LOG2   = 8;
  localparam int unsigned DATA_IN_W   = 16 + NFFT_LOG2 - 2;
  localparam int unsigned DATA_OUT_W  = 16;
  localparam int unsigned ROUND_SHIFT = NFFT_LOG2 - 2;

  typedef enum logic [0:0] {
    WFill = 1'b0,
    WFull = 1'b1
  } w_state_e;

  typedef enum logic [0:0] {
    RIdle = 1'b0,
    RSend = 1'b1
  } r_state_e;

endpackage

// File: rtl/ofdm_dp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module ofdm_dp_ram #(
  parameter int unsigned Width = 44,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/fft_frame_sink.sv
// FFT result sink: ping-pong frame capture, round/saturate rescaling and valid/ready replay.
// Optional FFT_FRAME_SINK_FFTSHIFT_EN reads each frame rotated by NFFT/2 (DC in the centre).
module fft_frame_sink
  import ofdm_pkg::*;
#(
  parameter int unsigned SIZE_BUFFER   = NFFT_LOG2,
  parameter int unsigned SIZE_DATA_IN  = DATA_IN_W,
  parameter int unsigned SIZE_DATA_OUT = DATA_OUT_W,
  parameter int unsigned SHIFT         = ROUND_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SIZE_DATA_IN-1:0]  fft_data_i,
  input  logic [SIZE_DATA_IN-1:0]  fft_data_q,
  input  logic                     fft_complete,
  output logic                     flag_ready_recive,
  output logic [SIZE_DATA_OUT-1:0] out_i,
  output logic [SIZE_DATA_OUT-1:0] out_q,
  output logic [SIZE_BUFFER-1:0]   out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     overflow
);

  localparam int unsigned Nfft  = 2 ** SIZE_BUFFER;
  localparam int unsigned RamW  = 2 * SIZE_DATA_IN;
  localparam int unsigned AddrW = SIZE_BUFFER + 1;
  localparam logic [SIZE_BUFFER-1:0] LastIdx = SIZE_BUFFER'(Nfft - 1);
  localparam logic signed [SIZE_DATA_IN:0] RoundBias = (SIZE_DATA_IN+1)'(2 ** (SHIFT - 1));
  localparam logic signed [SIZE_DATA_IN:0] SatMax =
      (SIZE_DATA_IN+1)'(2 ** (SIZE_DATA_OUT - 1) - 1);
  localparam logic signed [SIZE_DATA_IN:0] SatMin =
      (SIZE_DATA_IN+1)'(-(2 ** (SIZE_DATA_OUT - 1)));

  typedef struct packed {
    logic                     last;
    logic [SIZE_BUFFER-1:0]   idx;
    logic [SIZE_DATA_OUT-1:0] q;
    logic [SIZE_DATA_OUT-1:0] i;
  } sample_t;

  // Round half up at one extra bit of headroom, then clamp to the output range.
  function automatic logic [SIZE_DATA_OUT-1:0] scale(input logic [SIZE_DATA_IN-1:0] x);
    logic signed [SIZE_DATA_IN:0] ext;
    logic signed [SIZE_DATA_IN:0] sh;
    ext = $signed({x[SIZE_DATA_IN-1], x}) + RoundBias;
    sh  = ext >>> SHIFT;
    if (sh > SatMax) begin
      return SatMax[SIZE_DATA_OUT-1:0];
    end else if (sh < SatMin) begin
      return SatMin[SIZE_DATA_OUT-1:0];
    end
    return sh[SIZE_DATA_OUT-1:0];
  endfunction

  // Write side state
  w_state_e               w_state_q, w_state_d;
  logic [SIZE_BUFFER-1:0] wr_cnt_q;
  logic                   wr_bank_q;
  logic [1:0]             bank_full_q, bank_full_d;
  logic                   overflow_q;
  logic                   wr_en, wr_wrap;

  // Read side state
  r_state_e               r_state_q, r_state_d;
  logic [SIZE_BUFFER-1:0] rd_cnt_q, rd_pos;
  logic                   rd_bank_q;
  logic                   rd_done_q;
  logic                   rd_issue, rd_free, pop, room;
  logic                   rd_vld_q, rd_last_q;
  logic [SIZE_BUFFER-1:0] rd_idx_q;
  logic [1:0]             occ;
  logic [AddrW-1:0]       wr_addr, rd_addr;
  logic [RamW-1:0]        rd_data;

  // Output register plus skid entry
  sample_t obuf_q, obuf_d, skid_q, skid_d, in_sample;
  logic    obuf_valid_q, obuf_valid_d, skid_valid_q, skid_valid_d;

  assign wr_en   = fft_complete & flag_ready_recive;
  assign wr_wrap = wr_en & (wr_cnt_q == LastIdx);
  assign pop     = obuf_valid_q & out_ready;
  assign rd_free = pop & obuf_q.last;

  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_free) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
    if (wr_wrap) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
  end

  // Write FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= WFill;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  // Write FSM: next state; a bank freed this cycle lets the writer keep filling
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WFill: if (wr_wrap && bank_full_d[~wr_bank_q]) w_state_d = WFull;
      WFull: if (!bank_full_q[wr_bank_q]) w_state_d = WFill;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    flag_ready_recive = (w_state_q == WFill);
  end

  // Credits cover the in-flight RAM read, the output register and the skid entry.
  assign occ  = 2'(obuf_valid_q) + 2'(skid_valid_q) + 2'(rd_vld_q);
  assign room = (occ - 2'(pop)) < 2'd2;

  // Read FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= RIdle;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  // Read FSM: next state
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle: if (bank_full_q[rd_bank_q]) r_state_d = RSend;
      RSend: if (rd_free) r_state_d = RIdle;
    endcase
  end

  // Read FSM: outputs; the first read issues from idle to save a cycle of latency
  always_comb begin
    rd_issue = 1'b0;
    unique case (r_state_q)
      RIdle: rd_issue = bank_full_q[rd_bank_q] & room;
      RSend: rd_issue = ~rd_done_q & room;
    endcase
  end

`ifdef FFT_FRAME_SINK_FFTSHIFT_EN
  assign rd_pos = rd_cnt_q + SIZE_BUFFER'(Nfft / 2);
`else
  assign rd_pos = rd_cnt_q;
`endif

  assign wr_addr = {wr_bank_q, wr_cnt_q};
  assign rd_addr = {rd_bank_q, rd_pos};

  ofdm_dp_ram #(
    .Width (RamW),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i ({fft_data_i, fft_data_q}),
    .re_i    (rd_issue),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    in_sample.last = rd_last_q;
    in_sample.idx  = rd_idx_q;
    in_sample.i    = scale(rd_data[RamW-1:SIZE_DATA_IN]);
    in_sample.q    = scale(rd_data[SIZE_DATA_IN-1:0]);
  end

  always_comb begin
    obuf_d       = obuf_q;
    obuf_valid_d = obuf_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!obuf_valid_q || pop) begin
      if (skid_valid_q) begin
        obuf_d       = skid_q;
        obuf_valid_d = 1'b1;
        skid_valid_d = rd_vld_q;
        if (rd_vld_q) begin
          skid_d = in_sample;
        end
      end else begin
        obuf_valid_d = rd_vld_q;
        if (rd_vld_q) begin
          obuf_d = in_sample;
        end
      end
    end else if (rd_vld_q) begin
      skid_d       = in_sample;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      bank_full_q  <= '0;
      overflow_q   <= 1'b0;
      rd_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_idx_q     <= '0;
      rd_last_q    <= 1'b0;
      obuf_q       <= '0;
      obuf_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + SIZE_BUFFER'(1);
      end
      if (wr_wrap) begin
        wr_bank_q <= ~wr_bank_q;
      end
      bank_full_q <= bank_full_d;
      if (fft_complete && !flag_ready_recive) begin
        overflow_q <= 1'b1;
      end
      if (rd_free) begin
        rd_cnt_q  <= '0;
        rd_bank_q <= ~rd_bank_q;
        rd_done_q <= 1'b0;
      end else if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + SIZE_BUFFER'(1);
        if (rd_cnt_q == LastIdx) begin
          rd_done_q <= 1'b1;
        end
      end
      rd_vld_q <= rd_issue;
      if (rd_issue) begin
        rd_idx_q  <= rd_cnt_q;
        rd_last_q <= (rd_cnt_q == LastIdx);
      end
      obuf_q       <= obuf_d;
      obuf_valid_q <= obuf_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_i     = obuf_q.i;
  assign out_q     = obuf_q.q;
  assign out_index = obuf_q.idx;
  assign out_valid = obuf_valid_q;
  assign out_last  = obuf_q.last & obuf_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_frame_sink.sv
// Scoreboard bench for fft_frame_sink: frame-level reference model feeding an expectation
// queue, with an independent output monitor checking order, values, markers and hold.
module tb_fft_frame_sink;

  localparam int NB   = 8;
  localparam int N    = 2 ** NB;
  localparam int DIN  = 22;
  localparam int DOUT = 16;
  localparam int SH   = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DIN-1:0]  fft_data_i = '0;
  logic [DIN-1:0]  fft_data_q = '0;
  logic            fft_complete = 1'b0;
  logic            flag_ready_recive;
  logic [DOUT-1:0] out_i, out_q;
  logic [NB-1:0]   out_index;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_last;
  logic            overflow;

  fft_frame_sink #(
    .SIZE_BUFFER   (NB),
    .SIZE_DATA_IN  (DIN),
    .SIZE_DATA_OUT (DOUT),
    .SHIFT         (SH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fft_data_i        (fft_data_i),
    .fft_data_q        (fft_data_q),
    .fft_complete      (fft_complete),
    .flag_ready_recive (flag_ready_recive),
    .out_i             (out_i),
    .out_q             (out_q),
    .out_index         (out_index),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int i;
    int q;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_i[N];
  int   frame_q[N];
  int   rdy_mode = 1;
  int   nz_idx = -1;

  function automatic int ref_scale(input int x);
    int y;
    int hi;
    int lo;
    hi = 2 ** (DOUT - 1) - 1;
    lo = -(2 ** (DOUT - 1));
    y  = x + 2 ** (SH - 1);
    if (y >= 0) y = y / (2 ** SH);
    else        y = -((-y + 2 ** SH - 1) / (2 ** SH));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
  endfunction

  function automatic int rand_val();
    logic [DIN-1:0] v;
    case ($urandom_range(0, 3))
      0: begin
        v = DIN'($urandom);
        return int'($signed(v));
      end
      1: return int'($urandom_range(0, 65535)) - 32768;
      2: return ($urandom_range(0, 1) == 1) ? 2097151 : -2097152;
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      frame_i[k] = rand_val();
      frame_q[k] = rand_val();
    end
  endtask

  // Expected emission order: position p carries stored bin p, or bin p+N/2 when shifted.
  task automatic push_frame();
    exp_t e;
    int   a;
    for (int p = 0; p < N; p++) begin
      a = p;
`ifdef FFT_FRAME_SINK_FFTSHIFT_EN
      a = (p + N / 2) % N;
`endif
      e.idx  = p;
      e.i    = ref_scale(frame_i[a]);
      e.q    = ref_scale(frame_q[a]);
      e.last = (p == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_sample(input int vi, input int vq, input bit respect);
    int w;
    w = 0;
    if (respect) begin
      while (!flag_ready_recive && w < 5000) begin
        @(posedge clk);
        #1;
        w++;
      end
      check("flag_ready_wait", (w < 5000) ? 1 : 0, 1);
    end
    fft_data_i   = DIN'(vi);
    fft_data_q   = DIN'(vq);
    fft_complete = 1'b1;
    @(posedge clk);
    #1;
    fft_complete = 1'b0;
  endtask

  task automatic send_frame(input bit respect, input int gap_mode, input int count);
    for (int k = 0; k < count; k++) begin
      send_sample(frame_i[k], frame_q[k], respect);
      if (gap_mode == 1) begin
        @(posedge clk);
        #1;
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 20000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_out_index"}, int'(out_index), 0);
    check({tag, "_out_i"}, int'(out_i), 0);
    check({tag, "_out_q"}, int'(out_q), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_flag_ready"}, int'(flag_ready_recive), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor
  bit              stall_prev = 1'b0;
  logic [DOUT-1:0] p_i, p_q;
  logic [NB-1:0]   p_idx;
  logic            p_last;

  always @(negedge clk) begin
    exp_t e;
    int   ai;
    int   aq;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_i !== p_i || out_q !== p_q || out_index !== p_idx ||
            out_last !== p_last) begin
          errors++;
          $display("FAIL hold: valid=%0b idx=%0d i=%0d q=%0d, held idx=%0d i=%0d q=%0d",
                   out_valid, out_index, out_i, out_q, p_idx, p_i, p_q);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        ai = $signed(out_i);
        aq = $signed(out_q);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: idx=%0d i=%0d q=%0d, required none", out_index,
                   ai, aq);
        end else begin
          e = sb.pop_front();
          if (int'(out_index) != e.idx || ai != e.i || aq != e.q || out_last != e.last) begin
            errors++;
            $display("FAIL sample: got idx=%0d i=%0d q=%0d last=%0b, required idx=%0d i=%0d q=%0d last=%0b",
                     out_index, ai, aq, out_last, e.idx, e.i, e.q, e.last);
          end
          if (ai != 0) nz_idx = int'(out_index);
        end
      end
      stall_prev = out_valid && !out_ready;
      p_i    = out_i;
      p_q    = out_q;
      p_idx  = out_index;
      p_last = out_last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Constant frame, full throughput, first-output latency
    rdy_mode = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      frame_i[k] = 32000;
      frame_q[k] = -32000;
    end
    send_frame(1'b1, 0, N);
    push_frame();
    @(negedge clk);
    @(negedge clk);
    check("latency_not_yet", int'(out_valid), 0);
    @(negedge clk);
    check("latency_first_valid", int'(out_valid), 1);
    drain("const_frame");

    // Rounding and saturation corners under random backpressure
    fill_random();
    frame_i[0] = 32;       frame_q[0] = -32;
    frame_i[1] = -32;      frame_q[1] = 31;
    frame_i[2] = 31;       frame_q[2] = -31;
    frame_i[3] = 2097151;  frame_q[3] = -2097152;
    frame_i[4] = -2097152; frame_q[4] = 2097151;
    rdy_mode = 2;
    send_frame(1'b1, 0, N);
    push_frame();
    drain("round_sat");

    // Impulse at bin 5
    for (int k = 0; k < N; k++) begin
      frame_i[k] = 0;
      frame_q[k] = 0;
    end
    frame_i[5] = 500;
    nz_idx = -1;
    rdy_mode = 1;
    send_frame(1'b1, 0, N);
    push_frame();
    drain("impulse");
`ifdef FFT_FRAME_SINK_FFTSHIFT_EN
    check("impulse_index", nz_idx, N / 2 + 5);
`else
    check("impulse_index", nz_idx, 5);
`endif

    // Sparse input, one sample every other cycle
    fill_random();
    send_frame(1'b1, 1, N);
    push_frame();
    drain("sparse");
    check("sparse_overflow", int'(overflow), 0);

    // Back-to-back random frames with random gaps and backpressure
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      send_frame(1'b1, 2, N);
      push_frame();
    end
    drain("random_frames");
    check("random_overflow", int'(overflow), 0);

    // Three frames against a stalled consumer: two buffered, third dropped
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    fill_random();
    send_frame(1'b0, 0, N);
    push_frame();
    check("bp_ready_after_frame1", int'(flag_ready_recive), 1);
    fill_random();
    send_frame(1'b0, 0, N);
    push_frame();
    check("bp_ready_after_frame2", int'(flag_ready_recive), 0);
    check("bp_overflow_before_drop", int'(overflow), 0);
    fill_random();
    send_frame(1'b0, 0, N);
    check("bp_overflow_after_drop", int'(overflow), 1);
    check("bp_held_valid", int'(out_valid), 1);
    check("bp_held_index", int'(out_index), 0);
    rdy_mode = 1;
    drain("backpressure");
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_restored", int'(flag_ready_recive), 1);

    // Reset in the middle of a frame
    fill_random();
    send_frame(1'b1, 0, 100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    fill_random();
    send_frame(1'b1, 0, N);
    push_frame();
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
